icache: RTL
===========

Name: icache

Overview:
- Direct-mapped instruction cache that answers single-word fetch requests from the instruction fetch unit.
- On a miss it issues one word read to the memory controller, fills the line, then responds.
- Sits between the fetch unit and the memory controller.
- Fetch side protocol:
  - Requester pulses an enable with a PC and waits.
  - Cache pulses an enable with the instruction exactly once per accepted request.

Parameters:
- INDEX_W, 6, index bits; 2^INDEX_W lines, one 32-bit word per line.
- ADDR_W, 32, address width (matches REG_DAT_W).
- DATA_W, 32, instruction width (matches INS_DAT_W).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global ready; low freezes all state and outputs.
- iIF_En  in  1  fetch request pulse.
- iIF_Pc  in  ADDR_W  fetch address, sampled when iIF_En=1.
- oIF_En  out  1  response valid, one-cycle pulse.
- oIF_Ins  out  DATA_W  instruction; valid when oIF_En=1.
- oMC_En  out  1  memory read request pulse.
- oMC_Addr  out  ADDR_W  word-aligned read address, held until iMC_En.
- iMC_En  in  1  memory read data valid pulse.
- iMC_Dat  in  DATA_W  read word.

Behaviour:
- Address split:
  - pc[1:0] ignored (word access).
  - index = pc[INDEX_W+1:2].
  - tag = pc[ADDR_W-1:INDEX_W+2].
- Storage per line: valid bit, tag, data word. Valid bits cleared on rst; tag and data arrays are not reset.
- Reset values: oIF_En=0, oIF_Ins=0, oMC_En=0, oMC_Addr=0, state=IDLE, all valid=0.
- en=0: no state, array, or output register changes. A request pulse arriving while en=0 is lost; the requester only pulses while en=1.
- All registered outputs are cleared to 0 by default each enabled cycle, except:
  - oIF_Ins and oMC_Addr, which hold their last value;
  - any output the rules below set.
- FSM states:
  - IDLE:
    - On iIF_En=1, latch pc into pc_q.
    - Hit (valid[index] && tag match, combinational on iIF_Pc): next cycle oIF_En=1 and oIF_Ins=data[index]; stay IDLE. Hit latency is 1 cycle.
    - Miss: next cycle oMC_En=1 (single-cycle pulse) and oMC_Addr={pc[ADDR_W-1:2],2'b00}; go to MISS.
  - MISS:
    - Wait for iMC_En.
    - On iMC_En=1: write data[idx_q]=iMC_Dat, tag[idx_q]=tag_q, valid[idx_q]=1; next cycle oIF_En=1 and oIF_Ins=iMC_Dat; go to IDLE.
    - Miss latency is memory latency + 1 cycle.
- Request while in MISS: ignored, with no response. The fetch unit never issues one, and the bench checks that none is issued.
- iIF_En in the same cycle as the oIF_En response: accepted normally. Back-to-back hits give one response per cycle.
- Conflict miss (same index, different tag): overwrite the line; no write-back, since the cache is read-only.
- iMC_En while in IDLE: ignored; no array write.
- rst mid-MISS:
  - Return to IDLE and invalidate all lines.
  - A late iMC_En after reset is ignored.
  - No oIF_En is produced for the aborted request.
- Self-modifying code is not supported; there is no flush port.

Decomposition:
- Shared header:
  - REG_DAT_W and INS_DAT_W widths.
  - ICACHE_INDEX_W default.
  - FSM state encodings ICS_IDLE and ICS_MISS.
- One sub-module, icache_array: valid/tag/data storage.
  - Combinational read port returns hit and data for an index and tag.
  - One synchronous write port.
  - Synchronous valid clear on rst.
- The FSM and handshakes live in icache.

Test Plan:
- Cold miss:
  - Stimulus: rst, then iIF_En with pc=0x00000004; memory returns 0x00500093 after 3 cycles.
  - Response: one oMC_En pulse with addr 0x00000004; oIF_En with ins 0x00500093 one cycle after iMC_En.
- Hit after fill:
  - Stimulus: repeat pc=0x00000004.
  - Response: oIF_En exactly 1 cycle later with 0x00500093; no oMC_En.
- Conflict:
  - Stimulus: pc=0x00000104 (same index, new tag) with memory data 0x00A00113, then pc=0x00000004.
  - Response: two misses; second returns 0x00500093 refetched from memory.
- Stall:
  - Stimulus: en=0 for 5 cycles during MISS, with iMC_En held off; then en=1 and iMC_En.
  - Response: state and outputs frozen during stall; single correct response afterwards.
- Reset mid-miss:
  - Stimulus: rst asserted while in MISS, then a stray iMC_En.
  - Response: no oIF_En; next request to the same pc misses.
- Back-to-back hits:
  - Stimulus: fill pc=0x0 and pc=0x8, then requests on consecutive cycles.
  - Response: oIF_En on consecutive cycles with the correct words in order.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared widths, default geometry and FSM encodings for the instruction cache.
package icache_pkg;

    localparam int REG_DAT_W      = 32;
    localparam int INS_DAT_W      = 32;
    localparam int ICACHE_INDEX_W = 6;

    typedef enum logic {
        ICS_IDLE = 1'b0,
        ICS_MISS = 1'b1
    } ics_state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for a direct-mapped cache with one word per line.
// Reads are combinational. There is one synchronous write port. Only the valid bits are reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = REG_DAT_W - ICACHE_INDEX_W - 2,
    parameter int DATA_W  = INS_DAT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               rd_hit,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    // Lookup: a line hits when it is valid and its stored tag matches.
    always_comb begin
        rd_hit  = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
        rd_data = data_mem[rd_idx];
    end

    // A fill marks its line valid.
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Valid bits are cleared on reset. Reset invalidates the whole cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data are written on a fill. They carry no reset, so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache controller.
// A hit responds 1 cycle after the request.
// A miss sends a single word read to memory, fills the line and then responds.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int ADDR_W  = REG_DAT_W,
    parameter int DATA_W  = INS_DAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              iIF_En,
    input  logic [ADDR_W-1:0] iIF_Pc,
    output logic              oIF_En,
    output logic [DATA_W-1:0] oIF_Ins,
    output logic              oMC_En,
    output logic [ADDR_W-1:0] oMC_Addr,
    input  logic              iMC_En,
    input  logic [DATA_W-1:0] iMC_Dat
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    ics_state_t        state_q, state_d;
    logic [ADDR_W-1:2] pc_q, pc_d;
    logic              oif_en_q, oif_en_d;
    logic [DATA_W-1:0] oif_ins_q, oif_ins_d;
    logic              omc_en_q, omc_en_d;
    logic [ADDR_W-1:0] omc_addr_q, omc_addr_d;

    logic              rd_hit;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              pc_lsb_unused;

    // Fetches are whole words, so the byte offset is not used.
    assign pc_lsb_unused = ^iIF_Pc[1:0];

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (iIF_Pc[INDEX_W+1:2]),
        .rd_tag  (iIF_Pc[ADDR_W-1:INDEX_W+2]),
        .rd_hit  (rd_hit),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (pc_q[INDEX_W+1:2]),
        .wr_tag  (pc_q[ADDR_W-1:INDEX_W+2]),
        .wr_data (iMC_Dat)
    );

    // Next state and outputs.
    // When en is low everything holds. Otherwise pulses clear and data outputs hold.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        oif_en_d   = oif_en_q;
        oif_ins_d  = oif_ins_q;
        omc_en_d   = omc_en_q;
        omc_addr_d = omc_addr_q;
        wr_en      = 1'b0;
        if (en) begin
            oif_en_d = 1'b0;
            omc_en_d = 1'b0;
            case (state_q)
                ICS_IDLE: begin
                    if (iIF_En) begin
                        pc_d = iIF_Pc[ADDR_W-1:2];
                        if (rd_hit) begin
                            oif_en_d  = 1'b1;
                            oif_ins_d = rd_data;
                        end else begin
                            omc_en_d   = 1'b1;
                            omc_addr_d = {iIF_Pc[ADDR_W-1:2], 2'b00};
                            state_d    = ICS_MISS;
                        end
                    end
                end
                ICS_MISS: begin
                    // Fetch requests are ignored here. Only the memory reply advances the FSM.
                    if (iMC_En) begin
                        wr_en     = 1'b1;
                        oif_en_d  = 1'b1;
                        oif_ins_d = iMC_Dat;
                        state_d   = ICS_IDLE;
                    end
                end
                default: state_d = ICS_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ICS_IDLE;
            pc_q       <= '0;
            oif_en_q   <= 1'b0;
            oif_ins_q  <= '0;
            omc_en_q   <= 1'b0;
            omc_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            oif_en_q   <= oif_en_d;
            oif_ins_q  <= oif_ins_d;
            omc_en_q   <= omc_en_d;
            omc_addr_q <= omc_addr_d;
        end
    end

    assign oIF_En   = oif_en_q;
    assign oIF_Ins  = oif_ins_q;
    assign oMC_En   = omc_en_q;
    assign oMC_Addr = omc_addr_q;

endmodule
